sad_row_accumulator: RTL

//  Downstream consumer of the 8-fragment big memory read port (16 x 32-bit words per read).
//  Per accepted row, forms |frame - template| for 16 pixels and accumulates over ROWS rows.

---
 rtl/sad_row_accumulator_pkg.sv | 17 +
 rtl/sad_absdiff16.sv | 39 +++
 rtl/sad_row_accumulator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sad_row_accumulator_pkg.sv
// Shared definitions for the SAD row accumulator: default geometry and FSM state encoding.
package sad_row_accumulator_pkg;

  localparam int NUM_PIX_DEF = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int ROWS_DEF    = 16;
  localparam int SUM_W_DEF   = 32;
  localparam int ADDR_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sad_state_e;

endpackage

// File: rtl/sad_absdiff16.sv
// Combinational 16-lane unsigned absolute difference, plus a pairwise adder tree that
// reduces an (already registered) row of differences to one zero-extended sum.
module sad_absdiff16
  import sad_row_accumulator_pkg::*;
#(
  parameter int NUM_PIX = NUM_PIX_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  localparam int TREE_W = DATA_W + $clog2(NUM_PIX)
) (
  input  logic [NUM_PIX*DATA_W-1:0] frame_row,
  input  logic [NUM_PIX*DATA_W-1:0] tmpl_row,
  output logic [NUM_PIX*DATA_W-1:0] diff_row,
  input  logic [NUM_PIX*DATA_W-1:0] diff_in,
  output logic [TREE_W-1:0]         diff_sum
);

  for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_lane
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    assign a = frame_row[gi*DATA_W +: DATA_W];
    assign b = tmpl_row[gi*DATA_W +: DATA_W];
    assign diff_row[gi*DATA_W +: DATA_W] = (a >= b) ? (a - b) : (b - a);
  end

  // In-place pairwise reduction; NUM_PIX is expected to be a power of two.
  always_comb begin : tree
    logic [TREE_W-1:0] lvl [NUM_PIX];
    for (int i = 0; i < NUM_PIX; i++) begin
      lvl[i] = TREE_W'(diff_in[i*DATA_W +: DATA_W]);
    end
    for (int w = NUM_PIX / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
    end
    diff_sum = lvl[0];
  end

endmodule

// File: rtl/sad_row_accumulator.sv
// Accumulates the sum of absolute differences of ROWS template/frame rows per candidate,
// reports the block SAD and tracks the best (minimum) SAD with its candidate address.
module sad_row_accumulator
  import sad_row_accumulator_pkg::*;
#(
  parameter int NUM_PIX = NUM_PIX_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROWS    = ROWS_DEF,
  parameter int SUM_W   = SUM_W_DEF
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic [ADDR_W-1:0]         CandAddr,
  input  logic                      RowValid,
  input  logic [NUM_PIX*DATA_W-1:0] FrameRow,
  input  logic [NUM_PIX*DATA_W-1:0] TmplRow,
  input  logic                      ClearBest,
  output logic                      Busy,
  output logic                      Done,
  output logic [SUM_W-1:0]          SadOut,
  output logic [SUM_W-1:0]          BestSad,
  output logic [ADDR_W-1:0]         BestAddr
);

  localparam int ROW_W  = NUM_PIX * DATA_W;
  localparam int TREE_W = DATA_W + $clog2(NUM_PIX);
  localparam int CNT_W  = $clog2(ROWS + 1);
  localparam int EXT_W  = ((SUM_W > TREE_W) ? SUM_W : TREE_W) + 1;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] ROWS_CNT = CNT_W'(ROWS);
  localparam logic [EXT_W-1:0] SAT_MAX  = EXT_W'({SUM_W{1'b1}});

  sad_state_e state_reg;
  sad_state_e state_next;

  logic [CNT_W-1:0]  row_cnt_reg;
  logic              in_valid_reg;
  logic [ROW_W-1:0]  frame_reg;
  logic [ROW_W-1:0]  tmpl_reg;
  logic              s1_valid_reg;
  logic [ROW_W-1:0]  diff_reg;
  logic [ROW_W-1:0]  diff_row;
  logic [TREE_W-1:0] diff_sum;
  logic [SUM_W-1:0]  acc_reg;
  logic [SUM_W-1:0]  acc_next;
  logic [EXT_W-1:0]  acc_total;
  logic [ADDR_W-1:0] cand_reg;
  logic [SUM_W-1:0]  sad_reg;
  logic [SUM_W-1:0]  best_sad_reg;
  logic [ADDR_W-1:0] best_addr_reg;

  logic row_accept;
  logic last_row;
  logic enter_done;

  // Start dominates a coincident row: that row belongs to the abandoned candidate.
  assign row_accept = (state_reg == ST_ACCUM) && RowValid && !Start && (row_cnt_reg != ROWS_CNT);
  assign last_row   = row_accept && (row_cnt_reg == LAST_ROW);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (Start) begin
      state_next = ST_ACCUM;
    end else begin
      case (state_reg)
        ST_IDLE:  state_next = ST_IDLE;
        ST_ACCUM: if (last_row) state_next = ST_DRAIN;
        // The S1 stage is consumed on this edge, so only the input stage must be empty.
        ST_DRAIN: if (!in_valid_reg) state_next = ST_DONE;
        ST_DONE:  state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy = (state_reg == ST_ACCUM) || (state_reg == ST_DRAIN);
    Done = (state_reg == ST_DONE);
  end

  sad_absdiff16 #(
    .NUM_PIX (NUM_PIX),
    .DATA_W  (DATA_W)
  ) u_absdiff (
    .frame_row (frame_reg),
    .tmpl_row  (tmpl_reg),
    .diff_row  (diff_row),
    .diff_in   (diff_reg),
    .diff_sum  (diff_sum)
  );

  always_comb begin
    acc_total = EXT_W'(acc_reg) + EXT_W'(diff_sum);
    acc_next  = acc_reg;
    if (s1_valid_reg) begin
      acc_next = (acc_total > SAT_MAX) ? {SUM_W{1'b1}} : acc_total[SUM_W-1:0];
    end
  end

  assign enter_done = (state_reg == ST_DRAIN) && (state_next == ST_DONE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      row_cnt_reg  <= '0;
      in_valid_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      acc_reg      <= '0;
      cand_reg     <= '0;
    end else if (Start) begin
      row_cnt_reg  <= '0;
      in_valid_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      acc_reg      <= '0;
      cand_reg     <= CandAddr;
    end else begin
      in_valid_reg <= row_accept;
      s1_valid_reg <= in_valid_reg;
      acc_reg      <= acc_next;
      if (row_accept) begin
        row_cnt_reg <= row_cnt_reg + 1'b1;
      end
    end
  end

  // Wide datapath registers are qualified by the valids and need no reset.
  always_ff @(posedge Clk) begin
    if (row_accept) begin
      frame_reg <= FrameRow;
      tmpl_reg  <= TmplRow;
    end
    if (in_valid_reg) begin
      diff_reg <= diff_row;
    end
  end

  // Results land on the edge entering DONE so SadOut is final while Done is high.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sad_reg       <= '0;
      best_sad_reg  <= '1;
      best_addr_reg <= '0;
    end else begin
      if (enter_done) begin
        sad_reg <= acc_next;
      end
      if (ClearBest) begin
        best_sad_reg  <= '1;
        best_addr_reg <= '0;
      end else if (enter_done && (acc_next < best_sad_reg)) begin
        best_sad_reg  <= acc_next;
        best_addr_reg <= cand_reg;
      end
    end
  end

  assign SadOut   = sad_reg;
  assign BestSad  = best_sad_reg;
  assign BestAddr = best_addr_reg;

endmodule
